// File: rtl/alu_pkg.sv
// Shared opcode and state types for the iterative ALU.
// Codes 0000..0011 and 0101 keep the legacy single-cycle ALU's meaning.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLTU  = 4'b0101,
    OP_SLL   = 4'b0110,
    OP_SRL   = 4'b0111,
    OP_SRA   = 4'b1000,
    OP_SLT   = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101,
    OP_RSV_E = 4'b1110,
    OP_RSV_F = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iterative(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_divide(input alu_op_e op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// acc holds {high, low}: product for MUL/MULHU, {remainder, quotient} for DIVU/REMU.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt_q;
  alu_op_e            op_q;
  logic               busy_q;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_diff;

  // A clear sign bit on the trial subtraction means the divisor fits.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    acc_next = acc_q;
    if (is_divide(op_q)) begin
      if (!rem_diff[WIDTH]) acc_next = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  assign busy   = busy_q;
  assign done   = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign result = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? acc_next[2*WIDTH-1:WIDTH]
                                                            : acc_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      op_q   <= OP_ADD;
      busy_q <= 1'b0;
    end else if (start) begin
      acc_q  <= {{WIDTH{1'b0}}, a};
      b_q    <= b;
      cnt_q  <= '0;
      op_q   <= op;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle ops computed on accept, mul/div handed to alu_muldiv.
// Result and Zero are registered and held until the consumer takes them.
module alu_iter
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             Zero,
  output alu_state_e       state
);

  // Handshake: a request transfers on a cycle with in_valid & in_ready, a result
  // on a cycle with out_valid & out_ready; both sides may hold valid indefinitely.
  alu_state_e       state_q;
  alu_state_e       state_d;
  alu_op_e          op;
  logic             accept;
  logic             take_iter;
  logic [WIDTH-1:0] simple_result;
  logic [SHW-1:0]   shamt;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  assign op        = alu_op_e'(ALU_control);
  assign shamt     = SrcB[SHW-1:0];
  assign accept    = in_valid & in_ready;
  assign take_iter = is_iterative(op) && !(is_divide(op) && (SrcB == '0));
  assign state     = state_q;

  always_comb begin
    simple_result = '0;
    case (op)
      OP_ADD:  simple_result = SrcA + SrcB;
      OP_SUB:  simple_result = SrcA - SrcB;
      OP_AND:  simple_result = SrcA & SrcB;
      OP_OR:   simple_result = SrcA | SrcB;
      OP_XOR:  simple_result = SrcA ^ SrcB;
      OP_SLTU: simple_result = WIDTH'(SrcA < SrcB);
      OP_SLL:  simple_result = SrcA << shamt;
      OP_SRL:  simple_result = SrcA >> shamt;
      OP_SRA:  simple_result = WIDTH'($signed(SrcA) >>> shamt);
      OP_SLT:  simple_result = WIDTH'($signed(SrcA) < $signed(SrcB));
      OP_DIVU: simple_result = '1;
      OP_REMU: simple_result = SrcA;
      default: simple_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = take_iter ? S_BUSY : S_DONE;
      S_BUSY: if (md_done) state_d = S_DONE;
      S_DONE: begin
        if (accept)         state_d = take_iter ? S_BUSY : S_DONE;
        else if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    out_valid = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ALU_result <= '0;
      Zero       <= 1'b0;
    end else if (accept && !take_iter) begin
      ALU_result <= simple_result;
      Zero       <= (simple_result == '0);
    end else if ((state_q == S_BUSY) && md_done) begin
      ALU_result <= md_result;
      Zero       <= (md_result == '0);
    end
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && take_iter),
    .op     (op),
    .a      (SrcA),
    .b      (SrcB),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: directed cases plus random traffic against an arithmetic model,
// with a per-cycle monitor checking results, Zero, latency and in_ready.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [3:0]   ALU_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_result;
  logic         Zero;
  alu_state_e   state;

  alu_iter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .ALU_control (ALU_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALU_result  (ALU_result),
    .Zero        (Zero),
    .state       (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];
  bit           head_seen = 1'b0;
  bit           mon_en = 1'b0;
  bit           rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [63:0]         prod;
    logic signed [W-1:0] sa;
    int unsigned         sh;
    prod = {32'd0, a} * {32'd0, b};
    sa   = a;
    sh   = b % W;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return (a < b) ? 1 : 0;
      4'd6:    return a << sh;
      4'd7:    return a >> sh;
      4'd8:    return sa >>> sh;
      4'd9:    return (sa < $signed(b)) ? 1 : 0;
      4'd10:   return prod[31:0];
      4'd11:   return prod[63:32];
      4'd12:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13:   return (b == 0) ? a : a % b;
      default: return 0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] b);
    if (op >= 4'd10 && op <= 4'd13 && !(op >= 4'd12 && b == 0)) return W + 1;
    return 1;
  endfunction

  // monitor: sampled on the falling edge, inputs change just after the rising edge
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", in_ready, (exp_q.size() == 0) || (out_valid && out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          if (!head_seen) begin
            check("latency", cyc - acc_q[0], lat_q[0]);
            head_seen = 1'b1;
          end
          check("ALU_result", ALU_result, exp_q[0]);
          check("Zero", Zero, exp_q[0] == 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
            head_seen = 1'b0;
          end
        end
      end else if (exp_q.size() != 0 && (cyc - acc_q[0]) > 100) begin
        check("result_timeout", 0, 1);
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        void'(acc_q.pop_front());
        head_seen = 1'b0;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // drivers: called 1 time unit after a rising edge, return 1 unit after the accept edge
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int waited = 0;
    in_valid    = 1'b1;
    ALU_control = op;
    SrcA        = a;
    SrcB        = b;
    #1;
    while (!in_ready && waited < 200) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back(model(op, a, b));
      lat_q.push_back(model_lat(op, b));
      acc_q.push_back(cyc - 1);
    end
  endtask

  task automatic drop();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 0, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, state, S_IDLE);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_ALU_result"}, ALU_result, 0);
    check({tag, "_Zero"}, Zero, 0);
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    SrcA        = '0;
    SrcB        = '0;
    ALU_control = '0;
    idle(3);
    check_reset_state("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // hand-computed values that pin the model
    check("model_add_wrap", model(4'd0, 32'hFFFF_FFFF, 32'd1), 32'h0);
    check("model_slt", model(4'd9, 32'hFFFF_FFFF, 32'd1), 32'd1);
    check("model_sltu", model(4'd5, 32'hFFFF_FFFF, 32'd1), 32'd0);
    check("model_sra", model(4'd8, 32'h8000_0000, 32'h24), 32'hF800_0000);
    check("model_mul", model(4'd10, 32'h0001_0000, 32'h0001_0000), 32'h0);
    check("model_mulhu", model(4'd11, 32'h0001_0000, 32'h0001_0000), 32'h1);
    check("model_divu", model(4'd12, 32'd100, 32'd7), 32'd14);
    check("model_remu", model(4'd13, 32'd100, 32'd7), 32'd2);
    check("model_divu0", model(4'd12, 32'd5, 32'd0), 32'hFFFF_FFFF);
    check("model_remu0", model(4'd13, 32'd5, 32'd0), 32'd5);
    check("model_lat_mul", model_lat(4'd10, 32'd3), 33);
    check("model_lat_div0", model_lat(4'd12, 32'd0), 1);

    // directed single-cycle ops
    issue(4'd0, 32'hFFFF_FFFF, 32'd1);
    drop();
    idle(3);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1);
    issue(4'd5, 32'hFFFF_FFFF, 32'd1);
    issue(4'd8, 32'h8000_0000, 32'h24);
    drop();
    wait_drain();

    // directed iterative ops and divide-by-zero shortcut
    issue(4'd10, 32'h0001_0000, 32'h0001_0000);
    issue(4'd11, 32'h0001_0000, 32'h0001_0000);
    issue(4'd12, 32'd100, 32'd7);
    issue(4'd13, 32'd100, 32'd7);
    issue(4'd12, 32'd5, 32'd0);
    issue(4'd13, 32'd5, 32'd0);
    drop();
    wait_drain();

    // consumer stall, then back-to-back accept on release
    out_ready = 1'b0;
    issue(4'd0, 32'd10, 32'd20);
    fork
      issue(4'd0, 32'd3, 32'd4);
      begin
        idle(6);
        out_ready = 1'b1;
      end
    join
    drop();
    wait_drain();

    // reset in the middle of a divide
    issue(4'd12, $urandom, 32'd3);
    drop();
    idle(9);
    reset  = 1'b1;
    mon_en = 1'b0;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    head_seen = 1'b0;
    idle(1);
    check_reset_state("midop_reset");
    reset  = 1'b0;
    mon_en = 1'b1;
    issue(4'd0, 32'd2, 32'd3);
    drop();
    wait_drain();

    // random traffic with random consumer back-pressure
    rand_ready = 1'b1;
    repeat (300) begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 7);
        1:       b = $urandom_range(0, 255);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = $urandom_range(0, 3);
      issue(op, a, b);
      if ($urandom_range(0, 3) == 0) begin
        drop();
        idle($urandom_range(1, 3));
      end
    end
    drop();
    rand_ready = 1'b0;
    idle(1);
    out_ready = 1'b1;
    wait_drain();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, handshaked successor to the datapath's single-cycle ALU. It keeps the five legacy operations at their legacy codes and adds XOR, shifts, signed compare, and iterative unsigned multiply/divide. Results are registered and returned over a valid/ready interface, so the control FSM can stall on multi-cycle operations. It sits between the register-file/immediate operand muxes and the writeback/branch logic.

## Interface
- WIDTH, 32, datapath width; power of two, 8..64
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- SrcA  in  WIDTH  operand A
- SrcB  in  WIDTH  operand B; SrcB[SHW-1:0] is the shift amount
- ALU_control  in  4  opcode
- out_valid  out  1  ALU_result/Zero valid
- out_ready  in  1  consumer takes the result this cycle
- ALU_result  out  WIDTH  registered result
- Zero  out  1  registered; 1 iff ALU_result == 0

## Operation
- Opcodes; bit 3 = 0 with low three bits matching legacy codes:
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLTU (unsigned; legacy SLT behaviour)
  - 0110 SLL
  - 0111 SRL
  - 1000 SRA
  - 1001 SLT (signed)
  - 1010 MUL (low WIDTH bits)
  - 1011 MULHU (high WIDTH bits)
  - 1100 DIVU
  - 1101 REMU
  - 1110/1111: result 0, single-cycle
- All arithmetic is modulo 2^WIDTH. SLT/SLTU return 1 or 0, zero-extended.
- Shifts use only SrcB[SHW-1:0]. SRA replicates SrcA[WIDTH-1].
- MUL/MULHU: shift-add over WIDTH iterations into a 2*WIDTH accumulator.
- DIVU/REMU: restoring division over WIDTH iterations.
- Divide by zero: DIVU returns all ones, REMU returns SrcA. Single-cycle shortcut; no iteration.
- FSM states:
  - IDLE --(accept, simple op or div-by-0)--> DONE
  - IDLE --(accept, mul/div)--> BUSY
  - BUSY --(iteration counter reaches WIDTH-1)--> DONE
  - DONE --(out_ready & !in_valid)--> IDLE
  - DONE --(out_ready & in_valid)--> DONE or BUSY, per the new op (back-to-back accept)
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- Operands and opcode are captured only on accept (in_valid & in_ready). Input changes in BUSY are ignored.
- out_valid = (state == DONE). ALU_result and Zero stay stable while out_valid & !out_ready.
- Reset in any state, including mid-iteration: the operation is discarded and no result is produced.

## Timing
- Reset values:
  - state IDLE
  - out_valid 0
  - in_ready 1
  - ALU_result 0
  - Zero 0
  - iteration counter 0
- Simple ops: accept at edge T; out_valid high after edge T+1 (latency 1).
- MUL/MULHU/DIVU/REMU: accept at T; out_valid after edge T+WIDTH+1 (latency WIDTH+1).
- Throughput: one simple op per cycle when out_ready is held high.
- Zero is registered in the same cycle as ALU_result; never combinational from inputs.

## Structure
- Package alu_pkg:
  - alu_op_e: 4-bit enum of the opcodes above
  - alu_state_e: IDLE/BUSY/DONE
  - is_iterative(op) function
- Sub-module alu_muldiv holds the iterative engine:
  - ports: start, op, a, b, busy, done, result
  - parametrised on WIDTH
  - owns the accumulator, divisor/remainder registers and iteration counter
- Top level holds the FSM, the single-cycle ops and the output registers.

## Test plan
- WIDTH=32, ADD 0xFFFFFFFF + 1, out_ready=1 -> next cycle ALU_result=0, Zero=1, out_valid=1 for one cycle.
- SLT 0xFFFFFFFF vs 1 -> 1. SLTU on the same operands -> 0. SRA 0x80000000 by SrcB=0x24 (amount 4) -> 0xF8000000.
- MUL 0x0001_0000 * 0x0001_0000 -> ALU_result 0, Zero=1, out_valid exactly 33 cycles after accept. MULHU on the same operands -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each at latency 1.
- Hold out_ready=0 for 5 cycles after a result -> ALU_result stable, in_ready=0, new in_valid is not accepted. Release -> back-to-back ADD accepted in the same cycle.
- Assert reset 10 cycles into a DIVU -> next cycle IDLE, out_valid=0, ALU_result=0. Following ADD 2+3 -> 5 at latency 1.
